// File: rtl/xunit_sha256_sched.sv
// SHA-256 message-schedule Versat unit.
// Loads one 16-word block, then streams W_t/K_t for t=0..63.
module xunit_sha256_sched #(
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               running,
    output logic               done,
    input  logic [31:0]        in0,
    input  logic [31:0]        in1,
    input  logic [31:0]        in2,
    input  logic [31:0]        in3,
    input  logic [31:0]        in4,
    input  logic [31:0]        in5,
    input  logic [31:0]        in6,
    input  logic [31:0]        in7,
    input  logic [31:0]        in8,
    input  logic [31:0]        in9,
    input  logic [31:0]        in10,
    input  logic [31:0]        in11,
    input  logic [31:0]        in12,
    input  logic [31:0]        in13,
    input  logic [31:0]        in14,
    input  logic [31:0]        in15,
    output logic [31:0]        out0,
    output logic [31:0]        out1,
    output logic [31:0]        out2,
    input  logic [DELAY_W-1:0] delay0
);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, FIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        win [16];
    logic [31:0]        msg [16];
    logic [5:0]         t;
    logic [DELAY_W-1:0] delay;
    logic               valid;
    logic [31:0]        w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] i);
        case (i)
            6'd0:  k_rom = 32'h428a2f98;
            6'd1:  k_rom = 32'h71374491;
            6'd2:  k_rom = 32'hb5c0fbcf;
            6'd3:  k_rom = 32'he9b5dba5;
            6'd4:  k_rom = 32'h3956c25b;
            6'd5:  k_rom = 32'h59f111f1;
            6'd6:  k_rom = 32'h923f82a4;
            6'd7:  k_rom = 32'hab1c5ed5;
            6'd8:  k_rom = 32'hd807aa98;
            6'd9:  k_rom = 32'h12835b01;
            6'd10: k_rom = 32'h243185be;
            6'd11: k_rom = 32'h550c7dc3;
            6'd12: k_rom = 32'h72be5d74;
            6'd13: k_rom = 32'h80deb1fe;
            6'd14: k_rom = 32'h9bdc06a7;
            6'd15: k_rom = 32'hc19bf174;
            6'd16: k_rom = 32'he49b69c1;
            6'd17: k_rom = 32'hefbe4786;
            6'd18: k_rom = 32'h0fc19dc6;
            6'd19: k_rom = 32'h240ca1cc;
            6'd20: k_rom = 32'h2de92c6f;
            6'd21: k_rom = 32'h4a7484aa;
            6'd22: k_rom = 32'h5cb0a9dc;
            6'd23: k_rom = 32'h76f988da;
            6'd24: k_rom = 32'h983e5152;
            6'd25: k_rom = 32'ha831c66d;
            6'd26: k_rom = 32'hb00327c8;
            6'd27: k_rom = 32'hbf597fc7;
            6'd28: k_rom = 32'hc6e00bf3;
            6'd29: k_rom = 32'hd5a79147;
            6'd30: k_rom = 32'h06ca6351;
            6'd31: k_rom = 32'h14292967;
            6'd32: k_rom = 32'h27b70a85;
            6'd33: k_rom = 32'h2e1b2138;
            6'd34: k_rom = 32'h4d2c6dfc;
            6'd35: k_rom = 32'h53380d13;
            6'd36: k_rom = 32'h650a7354;
            6'd37: k_rom = 32'h766a0abb;
            6'd38: k_rom = 32'h81c2c92e;
            6'd39: k_rom = 32'h92722c85;
            6'd40: k_rom = 32'ha2bfe8a1;
            6'd41: k_rom = 32'ha81a664b;
            6'd42: k_rom = 32'hc24b8b70;
            6'd43: k_rom = 32'hc76c51a3;
            6'd44: k_rom = 32'hd192e819;
            6'd45: k_rom = 32'hd6990624;
            6'd46: k_rom = 32'hf40e3585;
            6'd47: k_rom = 32'h106aa070;
            6'd48: k_rom = 32'h19a4c116;
            6'd49: k_rom = 32'h1e376c08;
            6'd50: k_rom = 32'h2748774c;
            6'd51: k_rom = 32'h34b0bcb5;
            6'd52: k_rom = 32'h391c0cb3;
            6'd53: k_rom = 32'h4ed8aa4a;
            6'd54: k_rom = 32'h5b9cca4f;
            6'd55: k_rom = 32'h682e6ff3;
            6'd56: k_rom = 32'h748f82ee;
            6'd57: k_rom = 32'h78a5636f;
            6'd58: k_rom = 32'h84c87814;
            6'd59: k_rom = 32'h8cc70208;
            6'd60: k_rom = 32'h90befffa;
            6'd61: k_rom = 32'ha4506ceb;
            6'd62: k_rom = 32'hbef9a3f7;
            default: k_rom = 32'hc67178f2;
        endcase
    endfunction

    assign msg = '{in0, in1, in2, in3, in4, in5, in6, in7,
                   in8, in9, in10, in11, in12, in13, in14, in15};

    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    assign done  = (state == IDLE) || (state == FIN);
    assign out2  = {31'b0, valid};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (run) begin
            state_nxt = WAIT;
        end else if (running) begin
            unique case (state)
                WAIT:    if (delay == '0) state_nxt = STREAM;
                STREAM:  if (t == 6'd63) state_nxt = FIN;
                default: state_nxt = state;
            endcase
        end
    end

    // win[0] always holds the word currently presented on out0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay <= '0;
            t     <= '0;
            out0  <= '0;
            out1  <= '0;
            valid <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (run) begin
            delay <= delay0;
            valid <= 1'b0;
        end else if (running) begin
            if (state == WAIT) begin
                if (delay != '0) begin
                    delay <= delay - DELAY_W'(1);
                end else begin
                    for (int i = 0; i < 16; i++) win[i] <= msg[i];
                    t     <= '0;
                    out0  <= in0;
                    out1  <= k_rom(6'd0);
                    valid <= 1'b1;
                end
            end else if (state == STREAM) begin
                if (t == 6'd63) begin
                    valid <= 1'b0;
                end else begin
                    for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                    win[15] <= w_new;
                    t       <= t + 6'd1;
                    out0    <= win[1];
                    out1    <= k_rom(t + 6'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_xunit_sha256_sched.sv
// Randomized bench for xunit_sha256_sched against a
// reference schedule, protocol timing and SHA-256 rounds.
module tb_xunit_sha256_sched;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        running;
    logic        done;
    logic [31:0] m [16];
    logic [31:0] out0;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [6:0]  delay0;

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xunit_sha256_sched #(.DELAY_W(7)) dut (
        .clk(clk), .rst(rst), .run(run), .running(running), .done(done),
        .in0(m[0]), .in1(m[1]), .in2(m[2]), .in3(m[3]),
        .in4(m[4]), .in5(m[5]), .in6(m[6]), .in7(m[7]),
        .in8(m[8]), .in9(m[9]), .in10(m[10]), .in11(m[11]),
        .in12(m[12]), .in13(m[13]), .in14(m[14]), .in15(m[15]),
        .out0(out0), .out1(out1), .out2(out2), .delay0(delay0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_exp();
        for (int i = 0; i < 64; i++) begin
            if (i < 16) exp_w[i] = m[i];
            else exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                          + exp_w[i-7]
                          + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                          + exp_w[i-16];
        end
    endtask

    function automatic logic [31:0] digest0();
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
        e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
                   + ((e & f) ^ (~e & g)) + obs_k[i] + obs_w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
                   + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return a + 32'h6a09e667;
    endfunction

    // Runs one block; returns early once abort_at words have been seen.
    task automatic do_block(input int d, input int gap, input int abort_at);
        logic [31:0] p0, p1, p2;
        logic        pd;
        logic        r;
        int          cnt;
        int          n;
        build_exp();
        delay0  = 7'(d);
        run     = 1'b1;
        running = 1'($urandom_range(1));
        tick();
        run = 1'b0;
        check("run_valid", out2, 32'd0);
        check("run_done", {31'b0, done}, 32'd0);
        cnt = 0;
        n   = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            r       = ($urandom_range(99) < gap) ? 1'b0 : 1'b1;
            running = r;
            p0 = out0; p1 = out1; p2 = out2; pd = done;
            tick();
            if (!r) begin
                check("frz_out0", out0, p0);
                check("frz_out1", out1, p1);
                check("frz_out2", out2, p2);
                check("frz_done", {31'b0, done}, {31'b0, pd});
                continue;
            end
            cnt++;
            if (n == 64) begin
                check("fin_valid", out2, 32'd0);
                check("fin_done", {31'b0, done}, 32'd1);
                check("fin_out0", out0, exp_w[63]);
                check("fin_out1", out1, KT[63]);
                return;
            end
            check("done_low", {31'b0, done}, 32'd0);
            if (out2[0]) begin
                if (n == 0) check("latency", cnt, d + 1);
                check($sformatf("w%0d", n), out0, exp_w[n]);
                check($sformatf("k%0d", n), out1, KT[n]);
                obs_w[n] = out0;
                obs_k[n] = out1;
                n++;
                if (n == abort_at) return;
            end else begin
                check("valid_gap", n, 0);
            end
        end
        check("timeout_words", n, 64);
    endtask

    task automatic rand_msg();
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    initial begin
        rst     = 1'b0;
        run     = 1'b0;
        running = 1'b0;
        delay0  = '0;
        rand_msg();
        #12;
        check("rst_out0", out0, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_out2", out2, 32'd0);
        check("rst_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        running = 1'b1;
        tick();
        check("idle_done", {31'b0, done}, 32'd1);

        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        do_block(0, 0, 0);
        check("abc_w15", obs_w[15], 32'h00000018);
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000f0000);
        check("abc_digest0", digest0(), 32'hba7816bf);

        rand_msg();
        do_block(5, 0, 0);

        rand_msg();
        do_block($urandom_range(12), 30, 0);

        rand_msg();
        do_block(3, 0, 31);
        rand_msg();
        do_block(2, 10, 0);

        rand_msg();
        do_block(1, 0, 10);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out0", out0, 32'd0);
        check("arst_out1", out1, 32'd0);
        check("arst_out2", out2, 32'd0);
        check("arst_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        rst     = 1'b1;
        running = 1'b1;
        tick();
        tick();
        check("post_rst_done", {31'b0, done}, 32'd1);
        check("post_rst_valid", out2, 32'd0);

        for (int b = 0; b < 3; b++) begin
            rand_msg();
            do_block($urandom_range(20), $urandom_range(40), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
